// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the parity counter family.
//   MODE_ANY / MODE_EVEN / MODE_ODD / MODE_HOLD : 2-bit mode encodings
//   bottom_of(mode)        : lowest legal count for a mode (0 or 1)
//   top_of(mode, width)    : highest legal count for a mode at a given width
// Hold mode has no range of its own; it reports the full 0..MAX range so
// that limit indication stays well defined while the counter is frozen.
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic [1:0] MODE_ANY  = 2'b00;
  localparam logic [1:0] MODE_EVEN = 2'b01;
  localparam logic [1:0] MODE_ODD  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // Odd mode is the only one whose range starts above zero.
  function automatic logic bottom_of(input logic [1:0] mode);
    return (mode == MODE_ODD);
  endfunction

  // Computed in 64 bits so callers can size-cast down to WIDTH+1 without
  // any intermediate overflow.
  function automatic longint top_of(input logic [1:0] mode, input int width);
    longint max_v;
    max_v = (longint'(1) << width) - 1;
    if (mode == MODE_EVEN) begin
      return max_v - 1;
    end
    return max_v;
  endfunction

endpackage

// File: rtl/parity_align.sv
// -----------------------------------------------------------------------------
// parity_align
// Forces a value onto the parity grid of the selected mode.
//   value    [WIDTH-1:0] : value to align
//   mode     [1:0]       : counter mode
//   aligned  [WIDTH-1:0] : even -> LSB cleared, odd -> LSB set, else unchanged
//   mismatch             : value is not already on the grid for this mode
// Only the LSB is touched, so the result can never overflow.
// -----------------------------------------------------------------------------
module parity_align
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] aligned,
  output logic             mismatch
);

  always_comb begin
    aligned  = value;
    mismatch = 1'b0;
    case (mode)
      MODE_EVEN: begin
        aligned[0] = 1'b0;
        mismatch   = value[0];
      end
      MODE_ODD: begin
        aligned[0] = 1'b1;
        mismatch   = ~value[0];
      end
      default: begin
        aligned  = value;
        mismatch = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/parity_step_counter.sv
// -----------------------------------------------------------------------------
// parity_step_counter
// Up/down counter restricted to a parity grid (any / even / odd / hold) with
// parity-corrected load, wrap-or-saturate at the limits and a registered
// terminal-count pulse.
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   clear        : synchronous clear to the bottom of the current mode
//   en           : count enable
//   dir          : 1 = up, 0 = down
//   mode [1:0]   : 00 any, 01 even, 10 odd, 11 hold
//   wrap_cfg_we  : latch wrap_cfg into the policy register
//   wrap_cfg     : 1 = wrap, 0 = saturate
//   load         : synchronous parallel load (value is parity aligned)
//   load_val     : load value
//   count        : registered count
//   tc           : one-cycle pulse when a step hits / is blocked at a limit
//   at_limit     : combinational, count sits at the limit in the current dir
// Priority per edge: clear > load > hold > parity correction > en.
// -----------------------------------------------------------------------------
module parity_step_counter
  import counter_pkg::*;
#(
  parameter int   WIDTH        = 4,
  parameter logic WRAP_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             wrap_cfg_we,
  input  logic             wrap_cfg,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_limit
);

  logic             wrap_q;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  // Limits, step and count all carried in WIDTH+1 bits so the compares
  // below never depend on modulo wrap of the count width.
  logic [WIDTH:0]   top_x;
  logic [WIDTH:0]   bot_x;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   sum_x;

  logic [WIDTH-1:0] ld_aligned;
  logic             ld_mismatch;
  logic [WIDTH-1:0] cnt_aligned;
  logic             cnt_mismatch;

  parity_align #(.WIDTH(WIDTH)) u_align_load (
    .value    (load_val),
    .mode     (mode),
    .aligned  (ld_aligned),
    .mismatch (ld_mismatch)
  );

  parity_align #(.WIDTH(WIDTH)) u_align_count (
    .value    (count),
    .mode     (mode),
    .aligned  (cnt_aligned),
    .mismatch (cnt_mismatch)
  );

  always_comb begin
    top_x = (WIDTH+1)'(top_of(mode, WIDTH));
    bot_x = {{WIDTH{1'b0}}, bottom_of(mode)};
    inc_x = (mode == MODE_EVEN || mode == MODE_ODD) ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
    cnt_x = {1'b0, count};
    sum_x = cnt_x + inc_x;
  end

  assign at_limit = dir ? (cnt_x == top_x) : (cnt_x == bot_x);

  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (clear) begin
      count_nxt = bot_x[WIDTH-1:0];
    end else if (load) begin
      count_nxt = ld_aligned;
    end else if (mode == MODE_HOLD) begin
      count_nxt = count;
    end else if (en && cnt_mismatch) begin
      // Off-grid count (typically after a mode change): snap it onto the
      // grid this cycle instead of stepping.
      count_nxt = cnt_aligned;
    end else if (en) begin
      if (dir) begin
        if (sum_x > top_x) begin
          tc_nxt    = 1'b1;
          count_nxt = wrap_q ? bot_x[WIDTH-1:0] : top_x[WIDTH-1:0];
        end else begin
          count_nxt = sum_x[WIDTH-1:0];
        end
      end else begin
        if (cnt_x < bot_x + inc_x) begin
          tc_nxt    = 1'b1;
          count_nxt = wrap_q ? top_x[WIDTH-1:0] : bot_x[WIDTH-1:0];
        end else begin
          count_nxt = count - inc_x[WIDTH-1:0];
        end
      end
    end
  end

  // ld_mismatch is only informative on the load path; the aligned value is
  // loaded whether or not it had to be corrected.
  logic unused_ok;
  assign unused_ok = ld_mismatch;

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      tc     <= 1'b0;
      wrap_q <= WRAP_DEFAULT;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      if (wrap_cfg_we) begin
        wrap_q <= wrap_cfg;
      end
    end
  end

endmodule

// File: tb/tb_parity_step_counter.sv
module tb_parity_step_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear, en, dir, wrap_cfg_we, wrap_cfg, load;
  logic [1:0]   mode;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc;
  logic         at_limit;

  int n_checks = 0;
  int n_pass   = 0;

  parity_step_counter #(.WIDTH(W), .WRAP_DEFAULT(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .en          (en),
    .dir         (dir),
    .mode        (mode),
    .wrap_cfg_we (wrap_cfg_we),
    .wrap_cfg    (wrap_cfg),
    .load        (load),
    .load_val    (load_val),
    .count       (count),
    .tc          (tc),
    .at_limit    (at_limit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       dir;
    logic [1:0] md;
    logic       we;
    logic       cfg;
    logic       alc;   // check at_limit before the edge
    logic       eal;
    logic [3:0] ec;
    logic       et;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic drive(input logic c, input logic l, input int lv, input logic e,
                       input logic d, input logic [1:0] m, input logic we, input logic cfg);
    clear = c; load = l; load_val = lv[W-1:0]; en = e; dir = d; mode = m;
    wrap_cfg_we = we; wrap_cfg = cfg;
  endtask

  // ---------------- reference model (plain integer arithmetic) -------------
  int m_count, m_tc, m_wrap;

  function automatic int m_bot(input int md); return (md == 2) ? 1 : 0; endfunction
  function automatic int m_top(input int md); return (md == 1) ? MAX - 1 : MAX; endfunction
  function automatic int m_inc(input int md); return (md == 1 || md == 2) ? 2 : 1; endfunction
  function automatic int m_align(input int v, input int md);
    if (md == 1) return v - (v % 2);
    if (md == 2) return (v % 2 == 0) ? v + 1 : v;
    return v;
  endfunction

  task automatic m_step(input int c, input int l, input int lv, input int e,
                        input int d, input int md, input int we, input int cfg);
    int nc, nt;
    nc = m_count; nt = 0;
    if (c != 0) nc = m_bot(md);
    else if (l != 0) nc = m_align(lv, md);
    else if (md == 3) nc = m_count;
    else if (e != 0 && m_align(m_count, md) != m_count) nc = m_align(m_count, md);
    else if (e != 0) begin
      if (d != 0) begin
        if (m_count + m_inc(md) > m_top(md)) begin
          nt = 1; nc = (m_wrap != 0) ? m_bot(md) : m_top(md);
        end else nc = m_count + m_inc(md);
      end else begin
        if (m_count < m_bot(md) + m_inc(md)) begin
          nt = 1; nc = (m_wrap != 0) ? m_top(md) : m_bot(md);
        end else nc = m_count - m_inc(md);
      end
    end
    if (we != 0) m_wrap = cfg;
    m_count = nc; m_tc = nt;
  endtask

  initial begin
    drive(0, 0, 0, 0, 1, 2'b00, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", int'(count), 0);
    check("reset_tc", int'(tc), 0);
    @(negedge clk);
    reset = 1'b1;

    //            clr ld lv  en dir md     we cfg alc eal ec  et
    tv.push_back('{0, 1, 12, 0, 1, 2'b01, 0, 0, 0, 0, 12, 0});
    tv.push_back('{0, 0, 0,  1, 1, 2'b01, 0, 0, 0, 0, 14, 0});
    tv.push_back('{0, 0, 0,  1, 1, 2'b01, 0, 0, 1, 1, 0,  1});
    tv.push_back('{0, 0, 0,  1, 1, 2'b01, 0, 0, 0, 0, 2,  0});
    tv.push_back('{0, 1, 4,  0, 0, 2'b10, 1, 0, 0, 0, 5,  0});
    tv.push_back('{0, 0, 0,  1, 0, 2'b10, 0, 0, 0, 0, 3,  0});
    tv.push_back('{0, 0, 0,  1, 0, 2'b10, 0, 0, 0, 0, 1,  0});
    tv.push_back('{0, 0, 0,  1, 0, 2'b10, 0, 0, 1, 1, 1,  1});
    tv.push_back('{0, 0, 0,  1, 0, 2'b10, 0, 0, 1, 1, 1,  1});
    tv.push_back('{0, 1, 6,  0, 1, 2'b01, 0, 0, 0, 0, 6,  0});
    tv.push_back('{0, 0, 0,  1, 1, 2'b10, 0, 0, 1, 0, 7,  0});
    tv.push_back('{0, 0, 0,  1, 1, 2'b10, 0, 0, 1, 0, 9,  0});
    tv.push_back('{0, 0, 0,  1, 1, 2'b10, 0, 0, 1, 0, 11, 0});
    tv.push_back('{1, 0, 0,  0, 0, 2'b00, 1, 1, 0, 0, 0,  0});
    tv.push_back('{0, 0, 0,  1, 0, 2'b00, 0, 0, 1, 1, 15, 1});
    tv.push_back('{0, 0, 0,  1, 0, 2'b11, 0, 0, 0, 0, 15, 0});
    tv.push_back('{0, 0, 0,  1, 0, 2'b11, 0, 0, 0, 0, 15, 0});
    tv.push_back('{0, 0, 0,  1, 0, 2'b11, 0, 0, 0, 0, 15, 0});
    tv.push_back('{1, 1, 8,  0, 1, 2'b10, 0, 0, 0, 0, 1,  0});
    tv.push_back('{0, 1, 15, 0, 1, 2'b01, 0, 0, 0, 0, 14, 0});
    tv.push_back('{0, 1, 15, 0, 1, 2'b00, 0, 0, 0, 0, 15, 0});
    tv.push_back('{0, 0, 0,  1, 1, 2'b00, 0, 0, 1, 1, 0,  1});

    foreach (tv[i]) begin
      drive(tv[i].clr, tv[i].ld, int'(tv[i].lv), tv[i].en, tv[i].dir, tv[i].md,
            tv[i].we, tv[i].cfg);
      #1;
      if (tv[i].alc) check($sformatf("vec%0d_at_limit", i), int'(at_limit), int'(tv[i].eal));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), int'(count), int'(tv[i].ec));
      check($sformatf("vec%0d_tc", i), int'(tc), int'(tv[i].et));
      @(negedge clk);
    end

    // Async reset mid-cycle after switching to saturate and loading 9.
    drive(0, 1, 9, 0, 1, 2'b00, 1, 0);
    @(posedge clk); #1;
    check("pre_reset_count", int'(count), 9);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_tc", int'(tc), 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 1, 1, 2'b00, 0, 0);
    @(posedge clk); #1;
    check("resume_count", int'(count), 1);
    @(negedge clk);
    drive(0, 1, 15, 0, 1, 2'b00, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 2'b00, 0, 0);
    @(posedge clk); #1;
    check("policy_default_count", int'(count), 0);
    check("policy_default_tc", int'(tc), 1);

    // Randomised run against the model, starting from a fresh reset.
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_count = 0; m_tc = 0; m_wrap = 1;
    for (int k = 0; k < 400; k++) begin
      int c, l, lv, e, d, md, we, cfg, exp_al;
      c   = ($urandom_range(31) == 0) ? 1 : 0;
      l   = ($urandom_range(15) == 0) ? 1 : 0;
      lv  = $urandom_range(MAX);
      e   = ($urandom_range(3) != 0) ? 1 : 0;
      d   = (k / 40) % 2 == 0 ? int'($urandom_range(4) != 0) : int'($urandom_range(4) == 0);
      md  = ($urandom_range(7) == 0) ? 3 : int'($urandom_range(2));
      we  = ($urandom_range(15) == 0) ? 1 : 0;
      cfg = $urandom_range(1);
      drive(c[0], l[0], lv, e[0], d[0], md[1:0], we[0], cfg[0]);
      #1;
      if (md != 3) begin
        exp_al = (d != 0) ? int'(m_count == m_top(md)) : int'(m_count == m_bot(md));
        check("rand_at_limit", int'(at_limit), exp_al);
      end
      m_step(c, l, lv, e, d, md, we, cfg);
      @(posedge clk); #1;
      check("rand_count", int'(count), m_count);
      check("rand_tc", int'(tc), m_tc);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_step_counter.md
Name: parity_step_counter

Overview:
Parametrised successor to the fixed 4-bit even/odd up/down counter. Counts in a selectable parity mode (any, even-only, odd-only, hold) and supports both directions. Adds a parity-corrected parallel load, a choice of wrap or saturate at the limits, and a terminal-count pulse. Used as a general sequencing and address counter in the counter/sequencer library.

Parameters:
WIDTH, 4, width of count in bits (min 2).
WRAP_DEFAULT, 1, reset value of internal wrap policy register (1 wrap, 0 saturate).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous active-low reset; clears all state immediately on assertion.
clear  input  1  synchronous clear to parity bottom.
en  input  1  count enable.
dir  input  1  1 = up, 0 = down.
mode  input  2  00 any, 01 even, 10 odd, 11 hold.
wrap_cfg_we  input  1  latch wrap_cfg into the policy register.
wrap_cfg  input  1  1 wrap, 0 saturate.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  load value.
count  output  WIDTH  registered count.
tc  output  1  registered one-cycle terminal-count pulse.
at_limit  output  1  combinational; count equals top when dir=1, or bottom when dir=0, for the current mode.

Behaviour:
- Reset (reset=0): count=0, tc=0, wrap policy=WRAP_DEFAULT. The reset is asynchronous; release is synchronised externally.
- MAX = 2^WIDTH-1.
- Limits per mode:
  - any: bottom 0, top MAX.
  - even: bottom 0, top MAX-1.
  - odd: bottom 1, top MAX.
- Step size: INC=1 in any mode, INC=2 in even and odd modes.
- align(v): even mode clears the LSB (rounds down); odd mode sets the LSB (rounds up); any mode leaves v unchanged. align never overflows.
- Priority on each rising edge: clear > load > hold mode > misaligned count > en.
  - clear: count <= bottom(mode), tc <= 0.
  - load: count <= align(load_val), tc <= 0.
  - mode=11: count holds, tc <= 0, en ignored.
  - Parity mismatch with en=1: count <= align(count), tc <= 0. This is a one-cycle correction step with no increment.
  - en=1, up: if count+INC > top, wrap gives count <= bottom and saturate holds count at top; tc <= 1 in both cases. Otherwise count <= count+INC.
  - en=1, down: if count < bottom+INC, wrap gives count <= top and saturate holds count at bottom; tc <= 1 in both cases. Otherwise count <= count-INC.
  - en=0: count holds, tc <= 0.
- Compute the limit comparisons in WIDTH+1 bits; never rely on natural modulo overflow.
- In saturate mode, tc pulses on every enabled cycle that is blocked at the limit.
- wrap_cfg_we takes effect from the next edge. It is independent of the priority chain.
- A mode change mid-count takes effect on the same edge: limits and INC are evaluated from the current mode input.
- Reset asserted mid-count forces count=0 and tc=0 at once, with no clock required.

Decomposition:
- Shared package (counter_pkg) holds:
  - mode localparams: MODE_ANY, MODE_EVEN, MODE_ODD, MODE_HOLD.
  - limit helper functions bottom_of(mode) and top_of(mode, WIDTH).
- One combinational sub-module, parity_align, parameterised by WIDTH. Inputs: value and mode. Outputs: aligned value and a mismatch flag. It is reused for both the load path and the correction path.

Test Plan:
- WIDTH=4, even mode, up, wrap: load 12, en for 3 cycles -> count 14, 0, 2; tc=1 only in the cycle count becomes 0.
- Odd mode, down, saturate (wrap_cfg_we with wrap_cfg=0): load 4 -> count 5; en for 4 cycles -> 3, 1, 1, 1; tc=0,0,1,1.
- Even mode at count 6, switch to odd with en=1 -> correction to 7 (tc=0), then 9, 11; at_limit=0 throughout (dir=1, top=15).
- Any mode, down, wrap, from 0 -> 15 with tc=1; then hold mode with en=1 for 3 cycles -> count stays 15, tc=0.
- clear=1 and load=1 in the same cycle, odd mode -> count=1 (clear wins). load_val=15 in even mode -> count=14.
- Assert reset between clock edges while count=9 -> count=0 and tc=0 before the next edge. Deassert -> counting resumes from 0 on the first enabled edge, and the policy register is back at WRAP_DEFAULT.
